mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main data-memory block-RAM port between two requesters: the CPU data path and a DMA/render read engine.
- The DMA engine streams frame and sprite data.
- Sits between the CPU-side memory controller's main-memory outputs and the block RAM. Memory-mapped I/O decode stays upstream.
- CPU has priority. A starvation guard bounds DMA wait. Read data returns one cycle later and is steered to the requester that issued it.

Parameters:
- ADDR_W, 16, address width of both requesters and the memory port
- DATA_W, 16, data width
- STARVE_LIMIT, 8, consecutive denied DMA cycles before DMA is force-granted (1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cpu_req  in  1  CPU requests a memory access this cycle
- cpu_wr_en  in  1  CPU access is a write (qualified by cpu_req)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  CPU request not accepted this cycle; CPU must hold its request
- cpu_rdata  out  DATA_W  CPU read data
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after an accepted CPU read)
- dma_req  in  1  DMA requests a read
- dma_addr  in  ADDR_W  DMA read address
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rdata  out  DATA_W  DMA read data
- dma_rvalid  out  1  dma_rdata valid (one cycle after dma_gnt)
- mem_addr  out  ADDR_W  block-RAM address
- mem_wdata  out  DATA_W  block-RAM write data
- mem_wr_en  out  1  block-RAM write enable
- mem_rdata  in  DATA_W  block-RAM read data (registered in RAM, 1-cycle latency)

Behaviour:
- Everything is clocked on the rising edge of clk. Reset is synchronous and active-high. Grant is combinational from inputs plus registered state.
- Grant rule, each cycle:
  - force = (starve_cnt == STARVE_LIMIT) && dma_req.
  - CPU wins if cpu_req && !force. Otherwise DMA wins if dma_req.
- Accepted requests:
  - cpu_stall = cpu_req && !cpu_win.
  - dma_gnt = dma_win.
- Memory port:
  - The winner's address drives mem_addr.
  - mem_wr_en = cpu_win && cpu_wr_en.
  - mem_wdata = cpu_wdata always.
  - With no winner: mem_addr = 0, mem_wr_en = 0.
- Return-path FSM, register rd_owner:
  - States: NONE, CPU_RD, DMA_RD.
  - Next state is CPU_RD if the CPU read was accepted, DMA_RD if DMA was granted, else NONE. CPU writes set NONE.
- Read return:
  - In CPU_RD: cpu_rvalid = 1, cpu_rdata = mem_rdata.
  - In DMA_RD: dma_rvalid = 1, dma_rdata = mem_rdata.
  - A non-owner's rdata is 0 and its rvalid is 0.
  - Latency: request cycle N, data cycle N+1. Back-to-back accepted requests give one return per cycle, in order.
- Starvation counter (8 bit):
  - Increments when dma_req && !dma_gnt, saturating at STARVE_LIMIT.
  - Clears on dma_gnt or when dma_req is low.
  - A forced DMA grant lasts exactly one cycle, then the CPU regains priority.
- Simultaneous events:
  - If cpu_req and dma_req are both high, the CPU wins unless force.
  - A CPU write coinciding with force is stalled, not dropped. cpu_stall stays high until accepted.
- Reset:
  - rd_owner = NONE and starve_cnt = 0.
  - All registered outputs are 0: cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata.
  - Combinational outputs follow the rules with zero state.
  - A read accepted in the cycle of reset produces no rvalid after reset.
- No buffering:
  - Requesters hold address and data while stalled or not granted.
  - Deasserting a request before acceptance cancels it with no side effect.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined: starvation counter and force grant operate as above.
- Undefined: the counter is absent, force is constant 0, and the CPU has strict priority. The DMA may wait indefinitely while cpu_req is continuously high.

Test Plan:
- CPU read alone: cpu_req=1, cpu_wr_en=0, addr 0x0010 holding 0xBEEF -> cpu_stall=0, mem_addr=0x0010 same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xBEEF, dma_rvalid=0.
- CPU write then read: write 0x1234 to 0x0020 (mem_wr_en=1 one cycle, no rvalid next cycle), then read 0x0020 -> cpu_rdata=0x1234 one cycle later.
- Contention: cpu_req and dma_req both high for 20 cycles, STARVE_LIMIT=8, guard on -> CPU accepted cycles 0-7, dma_gnt=1 only in cycle 8 with cpu_stall=1 there, CPU wins cycles 9-16, dma_gnt again in cycle 17.
- Guard compiled out, same stimulus -> dma_gnt=0 all 20 cycles; dropping cpu_req -> dma_gnt=1 that same cycle, dma_rvalid next.
- Interleaved returns: CPU read 0x0001 (0x00AA) cycle 0, DMA read 0x0002 (0x00BB) cycle 1 -> cycle 1 cpu_rvalid/0x00AA, cycle 2 dma_rvalid/0x00BB, no cross-steering.
- Reset mid-operation: accepted DMA read in cycle N with reset=1 in cycle N -> dma_rvalid=0 at N+1, starve_cnt=0, outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one block-RAM port between the CPU data path and the DMA/render read
// engine. The CPU normally wins; a starvation guard force-grants the DMA for a
// single cycle once it has been denied STARVE_LIMIT consecutive cycles. Read
// data arrives one cycle after the request and is steered back to whichever
// requester issued it.
//
// Build option: define MEM_ARB_STARVE_GUARD_EN to enable the starvation guard.
// Without it the CPU has strict priority and the DMA may wait indefinitely.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   cpu_req/wr_en/addr/wdata          CPU access request
//   cpu_stall                         CPU request not accepted, hold it
//   cpu_rdata/cpu_rvalid              CPU read return
//   dma_req/dma_addr                  DMA read request
//   dma_gnt                           DMA request accepted
//   dma_rdata/dma_rvalid              DMA read return
//   mem_addr/wdata/wr_en              block-RAM port
//   mem_rdata                         block-RAM read data (1-cycle latency)
//
// Return-path states:
//   state  | meaning
//   NONE   | no read outstanding, both rvalid low
//   CPU_RD | CPU read issued last cycle, mem_rdata belongs to CPU
//   DMA_RD | DMA read issued last cycle, mem_rdata belongs to DMA

module mem_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_wr_en,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   output logic              dma_gnt,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr_en,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      CPU_RD = 2'd1,
      DMA_RD = 2'd2
   } rd_owner_t;

   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   rd_owner_t  rd_owner;
   logic [7:0] starve_cnt;
   logic       force_dma;
   logic       cpu_win;
   logic       dma_win;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD_EN = 1'b1;

   // Counts consecutive denied DMA cycles; any grant or a dropped request
   // restarts the count, so a forced grant lasts exactly one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!dma_req || dma_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + 8'd1;
      end
   end
`else
   localparam bit GUARD_EN = 1'b0;

   // No counter: tied off so force_dma reduces to a constant 0.
   assign starve_cnt = '0;
`endif

   assign force_dma = GUARD_EN && dma_req && (starve_cnt == STARVE_MAX);

   assign cpu_win   = cpu_req && !force_dma;
   assign dma_win   = dma_req && !cpu_win;

   assign cpu_stall = cpu_req && !cpu_win;
   assign dma_gnt   = dma_win;

   always_comb begin
      mem_addr = '0;
      if (cpu_win) begin
         mem_addr = cpu_addr;
      end else if (dma_win) begin
         mem_addr = dma_addr;
      end
   end

   assign mem_wr_en = cpu_win && cpu_wr_en;
   assign mem_wdata = cpu_wdata;

   // Remembers who issued last cycle's read; writes leave nothing to return.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_owner <= NONE;
      end else if (cpu_win && !cpu_wr_en) begin
         rd_owner <= CPU_RD;
      end else if (dma_win) begin
         rd_owner <= DMA_RD;
      end else begin
         rd_owner <= NONE;
      end
   end

   assign cpu_rvalid = (rd_owner == CPU_RD);
   assign dma_rvalid = (rd_owner == DMA_RD);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
   assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int SL = 8;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD_ON = 1'b1;
`else
   localparam bit GUARD_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_wr_en;
   logic [15:0] cpu_addr, cpu_wdata;
   logic        cpu_stall, cpu_rvalid;
   logic [15:0] cpu_rdata;
   logic        dma_req;
   logic [15:0] dma_addr;
   logic        dma_gnt, dma_rvalid;
   logic [15:0] dma_rdata;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_wr_en;
   logic [15:0] mem_rdata = 16'h0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt),
      .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata)
   );

   // Block RAM driven by the DUT's port: registered read, 1-cycle latency.
   logic [15:0] bram    [0:65535];
   logic [15:0] ref_mem [0:65535];

   always @(posedge clk) begin
      if (mem_wr_en) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic creq, input logic cwr,
                        input logic [15:0] caddr, input logic [15:0] cwd,
                        input logic dreq, input logic [15:0] daddr);
      @(posedge clk);
      #1;
      reset     = rst;
      cpu_req   = creq;
      cpu_wr_en = cwr;
      cpu_addr  = caddr;
      cpu_wdata = cwd;
      dma_req   = dreq;
      dma_addr  = daddr;
      #1;
   endtask

   typedef struct {
      logic        rst, creq, cwr;
      logic [15:0] caddr, cwd;
      logic        dreq;
      logic [15:0] daddr;
      logic        stall, gnt;
      logic [15:0] maddr;
      logic        we, crv;
      logic [15:0] crd;
      logic        drv;
      logic [15:0] drd;
   } vec_t;

   vec_t vt [17];

   // Reference-model state: consecutive DMA denials and the read expected back
   // next cycle (0 none, 1 CPU, 2 DMA) with the data it must carry.
   int          waited;
   int          pend_owner;
   logic [15:0] pend_data;
   logic        r_rst, r_creq, r_cwr, r_dreq;
   logic [15:0] r_caddr, r_cwd, r_daddr;
   logic        m_force, m_cw, m_dw, prev_force;

   initial begin
      reset = 1'b1; cpu_req = 0; cpu_wr_en = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_addr = 0;
      for (int i = 0; i < 65536; i++) bram[i] = 16'(i * 7 + 3);
      bram[16'h0010] = 16'hBEEF;
      bram[16'h0001] = 16'h00AA;
      bram[16'h0002] = 16'h00BB;

      //          rst creq cwr caddr     cwd       dreq daddr     stall gnt maddr     we crv crd       drv drd
      vt[0]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
      vt[1]  = '{0, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 0, 0, 16'h0010, 0, 0, 16'h0000, 0, 16'h0000};
      vt[2]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'hBEEF, 0, 16'h0000};
      vt[3]  = '{0, 1, 1, 16'h0020, 16'h1234, 0, 16'h0000, 0, 0, 16'h0020, 1, 0, 16'h0000, 0, 16'h0000};
      vt[4]  = '{0, 1, 0, 16'h0020, 16'h0000, 0, 16'h0000, 0, 0, 16'h0020, 0, 0, 16'h0000, 0, 16'h0000};
      vt[5]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h1234, 0, 16'h0000};
      vt[6]  = '{0, 1, 0, 16'h0001, 16'h0000, 0, 16'h0000, 0, 0, 16'h0001, 0, 0, 16'h0000, 0, 16'h0000};
      vt[7]  = '{0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 1, 16'h0002, 0, 1, 16'h00AA, 0, 16'h0000};
      vt[8]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h00BB};
      vt[9]  = '{0, 1, 0, 16'h0010, 16'h0000, 1, 16'h0002, 0, 0, 16'h0010, 0, 0, 16'h0000, 0, 16'h0000};
      vt[10] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'hBEEF, 0, 16'h0000};
      vt[11] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 1, 16'h0002, 0, 0, 16'h0000, 0, 16'h0000};
      vt[12] = '{0, 1, 1, 16'h0030, 16'h5555, 0, 16'h0000, 0, 0, 16'h0030, 1, 0, 16'h0000, 1, 16'h00BB};
      vt[13] = '{1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 1, 16'h0002, 0, 0, 16'h0000, 0, 16'h0000};
      vt[14] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
      vt[15] = '{0, 1, 0, 16'h0030, 16'h0000, 0, 16'h0000, 0, 0, 16'h0030, 0, 0, 16'h0000, 0, 16'h0000};
      vt[16] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h5555, 0, 16'h0000};

      repeat (3) @(posedge clk);

      // Directed vectors
      for (int i = 0; i < 17; i++) begin
         drive(vt[i].rst, vt[i].creq, vt[i].cwr, vt[i].caddr, vt[i].cwd, vt[i].dreq, vt[i].daddr);
         chk($sformatf("vec%0d cpu_stall", i),  cpu_stall,  vt[i].stall);
         chk($sformatf("vec%0d dma_gnt", i),    dma_gnt,    vt[i].gnt);
         chk($sformatf("vec%0d mem_addr", i),   mem_addr,   vt[i].maddr);
         chk($sformatf("vec%0d mem_wr_en", i),  mem_wr_en,  vt[i].we);
         chk($sformatf("vec%0d mem_wdata", i),  mem_wdata,  vt[i].cwd);
         chk($sformatf("vec%0d cpu_rvalid", i), cpu_rvalid, vt[i].crv);
         chk($sformatf("vec%0d cpu_rdata", i),  cpu_rdata,  vt[i].crd);
         chk($sformatf("vec%0d dma_rvalid", i), dma_rvalid, vt[i].drv);
         chk($sformatf("vec%0d dma_rdata", i),  dma_rdata,  vt[i].drd);
      end

      // Sustained contention: forced DMA grant every SL+1 cycles when guarded
      prev_force = 1'b0;
      for (int c = 0; c < 20; c++) begin
         drive(0, 1, 0, 16'h0010, 16'h0000, 1, 16'h0002);
         m_force = GUARD_ON && ((c % (SL + 1)) == SL);
         chk($sformatf("cont%0d dma_gnt", c),   dma_gnt,   m_force);
         chk($sformatf("cont%0d cpu_stall", c), cpu_stall, m_force);
         chk($sformatf("cont%0d mem_addr", c),  mem_addr,  m_force ? 16'h0002 : 16'h0010);
         if (c > 0) begin
            chk($sformatf("cont%0d dma_rvalid", c), dma_rvalid, prev_force);
            chk($sformatf("cont%0d cpu_rdata", c),  cpu_rdata,  prev_force ? 16'h0000 : 16'hBEEF);
         end
         prev_force = m_force;
      end
      drive(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0002);
      chk("drop_cpu dma_gnt", dma_gnt, 1'b1);
      chk("drop_cpu cpu_rvalid", cpu_rvalid, 1'b1);
      drive(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
      chk("drop_cpu dma_rvalid", dma_rvalid, 1'b1);
      chk("drop_cpu dma_rdata", dma_rdata, 16'h00BB);
      chk("drop_cpu cpu_rvalid_next", cpu_rvalid, 1'b0);

      // Reset mid-contention must restart the starvation count from zero
      for (int c = 0; c < 5; c++) drive(0, 1, 0, 16'h0010, 16'h0000, 1, 16'h0002);
      drive(1, 1, 0, 16'h0010, 16'h0000, 1, 16'h0002);
      chk("rst_cont dma_gnt", dma_gnt, 1'b0);
      for (int c = 0; c <= SL; c++) begin
         drive(0, 1, 0, 16'h0010, 16'h0000, 1, 16'h0002);
         chk($sformatf("rst_cont%0d dma_gnt", c), dma_gnt, GUARD_ON && (c == SL));
         if (c == 0) chk("rst_cont cpu_rvalid", cpu_rvalid, 1'b0);
      end

      // Randomized run against the reference model
      drive(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
      for (int i = 0; i < 65536; i++) begin
         bram[i]    = 16'(i * 13 + 5);
         ref_mem[i] = 16'(i * 13 + 5);
      end
      drive(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
      waited = 0; pend_owner = 0; pend_data = 16'h0;
      for (int i = 0; i < 3000; i++) begin
         r_rst   = ($urandom_range(63) == 0);
         r_creq  = ($urandom_range(9) < 7);
         r_cwr   = ($urandom_range(3) == 0);
         r_caddr = 16'($urandom_range(63));
         r_cwd   = 16'($urandom);
         r_dreq  = ($urandom_range(9) < 7);
         r_daddr = 16'($urandom_range(63));
         drive(r_rst, r_creq, r_cwr, r_caddr, r_cwd, r_dreq, r_daddr);

         m_force = GUARD_ON && r_dreq && (waited >= SL);
         m_cw    = r_creq && !m_force;
         m_dw    = r_dreq && !m_cw;
         chk($sformatf("rand%0d cpu_stall", i),  cpu_stall,  r_creq && !m_cw);
         chk($sformatf("rand%0d dma_gnt", i),    dma_gnt,    m_dw);
         chk($sformatf("rand%0d mem_addr", i),   mem_addr,   m_cw ? r_caddr : (m_dw ? r_daddr : 16'h0));
         chk($sformatf("rand%0d mem_wr_en", i),  mem_wr_en,  m_cw && r_cwr);
         chk($sformatf("rand%0d mem_wdata", i),  mem_wdata,  r_cwd);
         chk($sformatf("rand%0d cpu_rvalid", i), cpu_rvalid, pend_owner == 1);
         chk($sformatf("rand%0d cpu_rdata", i),  cpu_rdata,  (pend_owner == 1) ? pend_data : 16'h0);
         chk($sformatf("rand%0d dma_rvalid", i), dma_rvalid, pend_owner == 2);
         chk($sformatf("rand%0d dma_rdata", i),  dma_rdata,  (pend_owner == 2) ? pend_data : 16'h0);

         if (r_dreq && !m_dw && !r_rst) waited++;
         else waited = 0;
         if (r_rst) begin
            pend_owner = 0;
         end else if (m_cw && !r_cwr) begin
            pend_owner = 1; pend_data = ref_mem[r_caddr];
         end else if (m_dw) begin
            pend_owner = 2; pend_data = ref_mem[r_daddr];
         end else begin
            pend_owner = 0;
         end
         if (m_cw && r_cwr) ref_mem[r_caddr] = r_cwd;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
